// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types for the two-master SRAM Avalon-MM arbiter
//               (master identifiers and read-tag record).
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_id_t;

  typedef struct packed {
    logic    valid;
    arb_id_t id;
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/sram_arb_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_tag_pipe
// Description : READ_LAT-deep shift register of read tags. The tag leaving
//               the last stage lines up with the SRAM read data.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [READ_LAT];

  // Advance every tag one stage per cycle; reset discards all in-flight tags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < READ_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < READ_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[READ_LAT-1];

endmodule
`default_nettype wire

// File: rtl/sram_avn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_avn_arbiter
// Description : Two-master Avalon-MM arbiter in front of one SRAM controller.
//               m0 (display reader) has fixed priority over m1 (pixel
//               source). One registered command per cycle; read data is
//               steered back to the issuer through a tag pipeline.
//               Optional macro SRAM_ARB_STARVE_GUARD_EN forces a grant to m1
//               after STARVE_MAX consecutive denied cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_avn_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AVN_AW     = 18,
  parameter int AVN_DW     = 16,
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                m0_avn_read,
  input  logic [AVN_AW-1:0]   m0_avn_address,
  output logic                m0_avn_waitrequest,
  output logic [AVN_DW-1:0]   m0_avn_readdata,
  output logic                m0_avn_readdatavalid,
  input  logic                m1_avn_read,
  input  logic                m1_avn_write,
  input  logic [AVN_AW-1:0]   m1_avn_address,
  input  logic [AVN_DW-1:0]   m1_avn_writedata,
  input  logic [AVN_DW/8-1:0] m1_avn_byteenable,
  output logic                m1_avn_waitrequest,
  output logic [AVN_DW-1:0]   m1_avn_readdata,
  output logic                m1_avn_readdatavalid,
  output logic                sram_avn_read,
  output logic                sram_avn_write,
  output logic [AVN_AW-1:0]   sram_avn_address,
  output logic [AVN_DW-1:0]   sram_avn_writedata,
  output logic [AVN_DW/8-1:0] sram_avn_byteenable,
  input  logic [AVN_DW-1:0]   sram_avn_readdata
);

  localparam int BEW = AVN_DW / 8;

  if (READ_LAT < 1) begin : g_bad_read_lat
    $error("READ_LAT must be at least 1");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  logic                   m0_req;
  logic                   m1_req;
  logic                   starve_force;
  logic [NUM_MASTERS-1:0] grant;

  logic              cmd_rd_q,   cmd_rd_d;
  logic              cmd_wr_q,   cmd_wr_d;
  logic [AVN_AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [AVN_DW-1:0] cmd_wd_q,   cmd_wd_d;
  logic [BEW-1:0]    cmd_be_q,   cmd_be_d;
  arb_id_t           cmd_id_q,   cmd_id_d;

  rd_tag_t tag_in;
  rd_tag_t tag_out;

  assign m0_req = m0_avn_read;
  assign m1_req = m1_avn_read | m1_avn_write;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_force = (starve_cnt_q == CNT_W'(STARVE_MAX));

  // Count consecutive cycles in which m1 asks but is refused
  always_comb begin
    starve_cnt_d = '0;
    if (m1_req && !grant[ARB_M1]) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Same-cycle grant: m1 wins when m0 is idle or m1 has starved long enough
  always_comb begin
    grant = '0;
    if (!sys_rst) begin
      if (m1_req && (!m0_req || starve_force)) begin
        grant[ARB_M1] = 1'b1;
      end else if (m0_req) begin
        grant[ARB_M0] = 1'b1;
      end
    end
  end

  assign m0_avn_waitrequest = ~grant[ARB_M0];
  assign m1_avn_waitrequest = ~grant[ARB_M1];

  // Next command: load the winner's transfer, otherwise idle with fields held
  always_comb begin
    cmd_rd_d   = 1'b0;
    cmd_wr_d   = 1'b0;
    cmd_addr_d = cmd_addr_q;
    cmd_wd_d   = cmd_wd_q;
    cmd_be_d   = cmd_be_q;
    cmd_id_d   = cmd_id_q;
    if (grant[ARB_M0]) begin
      cmd_rd_d   = 1'b1;
      cmd_addr_d = m0_avn_address;
      cmd_wd_d   = '0;
      cmd_be_d   = '1;
      cmd_id_d   = ARB_M0;
    end else if (grant[ARB_M1]) begin
      // An illegal read+write from m1 is issued as a write
      cmd_wr_d   = m1_avn_write;
      cmd_rd_d   = m1_avn_read & ~m1_avn_write;
      cmd_addr_d = m1_avn_address;
      cmd_wd_d   = m1_avn_writedata;
      cmd_be_d   = m1_avn_byteenable;
      cmd_id_d   = ARB_M1;
    end
  end

  // Command register presented to the SRAM controller
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cmd_rd_q   <= 1'b0;
      cmd_wr_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_wd_q   <= '0;
      cmd_be_q   <= '0;
      cmd_id_q   <= ARB_M0;
    end else begin
      cmd_rd_q   <= cmd_rd_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_wd_q   <= cmd_wd_d;
      cmd_be_q   <= cmd_be_d;
      cmd_id_q   <= cmd_id_d;
    end
  end

  assign sram_avn_read       = cmd_rd_q;
  assign sram_avn_write      = cmd_wr_q;
  assign sram_avn_address    = cmd_addr_q;
  assign sram_avn_writedata  = cmd_wd_q;
  assign sram_avn_byteenable = cmd_be_q;

  assign tag_in = '{valid: cmd_rd_q, id: cmd_id_q};

  sram_arb_tag_pipe #(
    .READ_LAT (READ_LAT)
  ) u_tag_pipe (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign m0_avn_readdatavalid = tag_out.valid & (tag_out.id == ARB_M0);
  assign m1_avn_readdatavalid = tag_out.valid & (tag_out.id == ARB_M1);
  assign m0_avn_readdata      = sram_avn_readdata;
  assign m1_avn_readdata      = sram_avn_readdata;

endmodule
`default_nettype wire
